// File: rtl/led_pio_blink.sv
// Avalon-MM LED output port with atomic set/clear and per-bit blink.
// Blink phase comes from a prescaler tick feeding a half-period counter.
module led_pio_blink #(
  parameter int                 WIDTH          = 10,
  parameter logic [WIDTH-1:0]   RESET_VALUE    = '0,
  parameter int                 PERIOD_WIDTH   = 16,
  parameter int                 PRESCALE_WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_MODE     = 3'd1;
  localparam logic [2:0] ADDR_OUTSET   = 3'd2;
  localparam logic [2:0] ADDR_OUTCLEAR = 3'd3;
  localparam logic [2:0] ADDR_PERIOD   = 3'd4;
  localparam logic [2:0] ADDR_PRESCALE = 3'd5;

  logic [WIDTH-1:0]          data_reg;
  logic [WIDTH-1:0]          mode_reg;
  logic [PERIOD_WIDTH-1:0]   period_reg;
  logic [PRESCALE_WIDTH-1:0] prescale_reg;
  logic [PRESCALE_WIDTH-1:0] pcnt;
  logic [PERIOD_WIDTH-1:0]   hcnt;
  logic                      phase;

  logic wr_en;
  logic restart;
  logic tick;
  logic unused_wdata;

  assign wr_en   = chipselect & ~write_n;
  assign restart = wr_en & ((address == ADDR_PERIOD) | (address == ADDR_PRESCALE));
  assign tick    = (pcnt == prescale_reg);
  assign unused_wdata = ^writedata;

  always_ff @(posedge clk) begin
    if (reset) begin
      data_reg     <= RESET_VALUE;
      mode_reg     <= '0;
      period_reg   <= '0;
      prescale_reg <= '0;
    end else if (wr_en) begin
      case (address)
        ADDR_DATA:     data_reg     <= writedata[WIDTH-1:0];
        ADDR_MODE:     mode_reg     <= writedata[WIDTH-1:0];
        ADDR_OUTSET:   data_reg     <= data_reg | writedata[WIDTH-1:0];
        ADDR_OUTCLEAR: data_reg     <= data_reg & ~writedata[WIDTH-1:0];
        ADDR_PERIOD:   period_reg   <= writedata[PERIOD_WIDTH-1:0];
        ADDR_PRESCALE: prescale_reg <= writedata[PRESCALE_WIDTH-1:0];
        default: ;
      endcase
    end
  end

  // A timing write restarts the blink in the on half; PERIOD=0 parks it there.
  always_ff @(posedge clk) begin
    if (reset || restart || (period_reg == '0)) begin
      pcnt  <= '0;
      hcnt  <= '0;
      phase <= 1'b1;
    end else if (tick) begin
      pcnt <= '0;
      if (hcnt == period_reg - PERIOD_WIDTH'(1)) begin
        hcnt  <= '0;
        phase <= ~phase;
      end else begin
        hcnt <= hcnt + PERIOD_WIDTH'(1);
      end
    end else begin
      pcnt <= pcnt + PRESCALE_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) out_port <= '0;
    else       out_port <= data_reg & (~mode_reg | {WIDTH{phase}});
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:     readdata[WIDTH-1:0]          = data_reg;
      ADDR_MODE:     readdata[WIDTH-1:0]          = mode_reg;
      ADDR_PERIOD:   readdata[PERIOD_WIDTH-1:0]   = period_reg;
      ADDR_PRESCALE: readdata[PRESCALE_WIDTH-1:0] = prescale_reg;
      default:       readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_led_pio_blink.sv
// Directed bench for led_pio_blink: register access, set/clear, blink timing.
module tb_led_pio_blink;

  logic        clk;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [9:0]  out_port;

  int errors = 0;
  int checks = 0;

  led_pio_blink #(
    .WIDTH(10),
    .RESET_VALUE(10'h2A0),
    .PERIOD_WIDTH(16),
    .PRESCALE_WIDTH(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .readdata(readdata),
    .out_port(out_port)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Leaves the caller 1ns after the next rising edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Write lands on the next edge; returns 1ns after it.
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  task automatic rd(input string tag, input logic [2:0] a, input logic [31:0] exp);
    address = a;
    #1;
    chk(tag, readdata, exp);
  endtask

  initial begin
    reset      = 1'b1;
    address    = '0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;

    step(3);
    chk("out_in_reset", {22'd0, out_port}, 32'h0);
    reset = 1'b0;
    chk("out_first_cycle_after_reset", {22'd0, out_port}, 32'h0);
    step(1);
    chk("out_reset_value", {22'd0, out_port}, 32'h2A0);
    rd("rd_data_reset", 3'd0, 32'h2A0);
    rd("rd_mode_reset", 3'd1, 32'h0);
    rd("rd_period_reset", 3'd4, 32'h0);
    rd("rd_prescale_reset", 3'd5, 32'h0);

    // DATA, OUTSET, OUTCLEAR; upper writedata bits are discarded
    wr(3'd0, 32'hFFFF_F0F0);
    chk("out_before_data_update", {22'd0, out_port}, 32'h2A0);
    step(1);
    chk("out_data_0f0", {22'd0, out_port}, 32'h0F0);
    rd("rd_data_truncated", 3'd0, 32'h0F0);
    wr(3'd2, 32'h0000_0003);
    step(1);
    chk("out_outset", {22'd0, out_port}, 32'h0F3);
    wr(3'd3, 32'h0000_0030);
    chk("out_before_outclear", {22'd0, out_port}, 32'h0F3);
    step(1);
    chk("out_outclear", {22'd0, out_port}, 32'h0C3);
    rd("rd_outset_zero", 3'd2, 32'h0);
    rd("rd_outclear_zero", 3'd3, 32'h0);
    rd("rd_data_after_clr", 3'd0, 32'h0C3);

    // Blink: PRESCALE=1, PERIOD=3 -> 6-clock half periods
    wr(3'd0, 32'h3FF);
    wr(3'd1, 32'h00F);
    wr(3'd5, 32'h1);
    wr(3'd4, 32'h3);
    rd("rd_period", 3'd4, 32'h3);
    rd("rd_prescale", 3'd5, 32'h1);
    rd("rd_mode", 3'd1, 32'h00F);
    step(6);
    chk("blink_on_end", {22'd0, out_port}, 32'h3FF);
    step(1);
    chk("blink_off_start", {22'd0, out_port}, 32'h3F0);
    step(5);
    chk("blink_off_end", {22'd0, out_port}, 32'h3F0);
    step(1);
    chk("blink_on_again", {22'd0, out_port}, 32'h3FF);
    step(6);
    chk("blink_off_2", {22'd0, out_port}, 32'h3F0);
    step(2);
    chk("blink_mid_off", {22'd0, out_port}, 32'h3F0);

    // Restart mid off-phase
    wr(3'd4, 32'h3);
    chk("restart_out_lag", {22'd0, out_port}, 32'h3F0);
    step(1);
    chk("restart_on", {22'd0, out_port}, 32'h3FF);
    step(5);
    chk("restart_on_end", {22'd0, out_port}, 32'h3FF);
    step(1);
    chk("restart_toggle", {22'd0, out_port}, 32'h3F0);

    // PERIOD=0 holds blinking channels at steady DATA
    wr(3'd4, 32'h0);
    wr(3'd1, 32'h3FF);
    wr(3'd0, 32'h155);
    step(1);
    chk("steady_start", {22'd0, out_port}, 32'h155);
    for (int i = 0; i < 3; i++) begin
      step(7);
      chk("steady_hold", {22'd0, out_port}, 32'h155);
    end

    // Reserved address writes are ignored
    wr(3'd6, 32'hFFFF_FFFF);
    rd("rd_reserved6", 3'd6, 32'h0);
    rd("rd_reserved7", 3'd7, 32'h0);
    rd("rd_data_after_rsvd", 3'd0, 32'h155);
    rd("rd_mode_after_rsvd", 3'd1, 32'h3FF);
    rd("rd_period_after_rsvd", 3'd4, 32'h0);
    rd("rd_prescale_after_rsvd", 3'd5, 32'h1);
    step(2);
    chk("out_after_rsvd", {22'd0, out_port}, 32'h155);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
